// File: rtl/apb3_arb_mux.sv
// apb3_arb_mux: round-robin arbiter/mux from two APB3 initiators onto one APB3 target.
// Optional macro APB3_ARB_TIMEOUT_EN forces an error completion after TIMEOUT_CYCLES wait states.
module apb3_arb_mux #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  APBI0_PSEL,
  input  logic                  APBI0_PWRITE,
  input  logic                  APBI0_PENABLE,
  input  logic [ADDR_WIDTH-1:0] APBI0_PADDR,
  input  logic [DATA_WIDTH-1:0] APBI0_PWDATA,
  output logic                  APBI0_PREADY,
  output logic                  APBI0_PSLVERR,
  output logic [DATA_WIDTH-1:0] APBI0_PRDATA,
  input  logic                  APBI1_PSEL,
  input  logic                  APBI1_PWRITE,
  input  logic                  APBI1_PENABLE,
  input  logic [ADDR_WIDTH-1:0] APBI1_PADDR,
  input  logic [DATA_WIDTH-1:0] APBI1_PWDATA,
  output logic                  APBI1_PREADY,
  output logic                  APBI1_PSLVERR,
  output logic [DATA_WIDTH-1:0] APBI1_PRDATA,
  output logic                  APBT_PSEL,
  output logic                  APBT_PENABLE,
  output logic                  APBT_PWRITE,
  output logic [ADDR_WIDTH-1:0] APBT_PADDR,
  output logic [DATA_WIDTH-1:0] APBT_PWDATA,
  input  logic                  APBT_PREADY,
  input  logic                  APBT_PSLVERR,
  input  logic [DATA_WIDTH-1:0] APBT_PRDATA,
  output logic                  APB_MUX_SEL
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state_q;
  logic grant_q, last_q, psel_q, pen_q;
  logic tmo, done, resp, pick;
  logic [DATA_WIDTH-1:0] rdata;
  logic unused_penable;
  assign unused_penable = APBI0_PENABLE ^ APBI1_PENABLE;
`ifdef APB3_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  assign tmo = state_q == ACCESS && !APBT_PREADY && cnt_q == CW'(TIMEOUT_CYCLES);
  always_ff @(posedge PCLK)
    if (PRESET) cnt_q <= '0;
    else if (state_q == SETUP) cnt_q <= '0;
    else if (state_q == ACCESS && !APBT_PREADY && !tmo) cnt_q <= cnt_q + CW'(1);
`else
  assign tmo = 1'b0;
`endif
  // Both requesting: the one not served last wins.
  assign pick = (APBI0_PSEL && APBI1_PSEL) ? ~last_q : APBI1_PSEL;
  assign done = state_q == ACCESS && (APBT_PREADY || tmo);
  always_ff @(posedge PCLK)
    if (PRESET) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      psel_q  <= 1'b0;
      pen_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (APBI0_PSEL || APBI1_PSEL) begin
          grant_q <= pick;
          state_q <= SETUP;
          psel_q  <= 1'b1;
        end
        SETUP: begin
          state_q <= ACCESS;
          pen_q   <= 1'b1;
        end
        default: if (done) begin
          last_q  <= grant_q;
          state_q <= IDLE;
          psel_q  <= 1'b0;
          pen_q   <= 1'b0;
        end
      endcase
    end
  assign APBT_PSEL    = psel_q;
  assign APBT_PENABLE = pen_q;
  assign APB_MUX_SEL  = grant_q;
  assign APBT_PWRITE  = grant_q ? APBI1_PWRITE : APBI0_PWRITE;
  assign APBT_PADDR   = grant_q ? APBI1_PADDR  : APBI0_PADDR;
  assign APBT_PWDATA  = grant_q ? APBI1_PWDATA : APBI0_PWDATA;
  // A completion coinciding with reset is abandoned, not reported.
  assign resp  = done && !PRESET;
  assign rdata = tmo ? '0 : APBT_PRDATA;
  assign APBI0_PREADY  = resp && !grant_q;
  assign APBI1_PREADY  = resp && grant_q;
  assign APBI0_PSLVERR = APBI0_PREADY && (APBT_PSLVERR || tmo);
  assign APBI1_PSLVERR = APBI1_PREADY && (APBT_PSLVERR || tmo);
  assign APBI0_PRDATA  = APBI0_PREADY ? rdata : '0;
  assign APBI1_PRDATA  = APBI1_PREADY ? rdata : '0;
endmodule

// File: tb/tb_apb3_arb_mux.sv
// tb_apb3_arb_mux: directed-vector bench for apb3_arb_mux (timeout case under APB3_ARB_TIMEOUT_EN).
module tb_apb3_arb_mux;
  logic PCLK = 1'b0, PRESET = 1'b1;
  logic i0_sel = 0, i0_wr = 0, i0_en = 0, i1_sel = 0, i1_wr = 0, i1_en = 0;
  logic [31:0] i0_addr = 0, i0_wdata = 0, i1_addr = 0, i1_wdata = 0;
  logic i0_rdy, i0_err, i1_rdy, i1_err;
  logic [31:0] i0_rdata, i1_rdata;
  logic t_sel, t_en, t_wr, t_rdy = 0, t_err = 0, mux_sel;
  logic [31:0] t_addr, t_wdata, t_rdata = 0;
  int checks = 0, errors = 0;

  apb3_arb_mux #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .APBI0_PSEL(i0_sel), .APBI0_PWRITE(i0_wr), .APBI0_PENABLE(i0_en),
    .APBI0_PADDR(i0_addr), .APBI0_PWDATA(i0_wdata),
    .APBI0_PREADY(i0_rdy), .APBI0_PSLVERR(i0_err), .APBI0_PRDATA(i0_rdata),
    .APBI1_PSEL(i1_sel), .APBI1_PWRITE(i1_wr), .APBI1_PENABLE(i1_en),
    .APBI1_PADDR(i1_addr), .APBI1_PWDATA(i1_wdata),
    .APBI1_PREADY(i1_rdy), .APBI1_PSLVERR(i1_err), .APBI1_PRDATA(i1_rdata),
    .APBT_PSEL(t_sel), .APBT_PENABLE(t_en), .APBT_PWRITE(t_wr),
    .APBT_PADDR(t_addr), .APBT_PWDATA(t_wdata),
    .APBT_PREADY(t_rdy), .APBT_PSLVERR(t_err), .APBT_PRDATA(t_rdata),
    .APB_MUX_SEL(mux_sel)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic reset_dut();
    PRESET = 1'b1;
    tick();
    tick();
    PRESET = 1'b0;
  endtask

  initial begin
    reset_dut();
    chk("rst_psel", t_sel, 0);
    chk("rst_pen", t_en, 0);
    chk("rst_mux", mux_sel, 0);
    chk("rst_resp", {i0_rdy, i0_err, i1_rdy, i1_err}, 0);
    chk("rst_rdata", i0_rdata | i1_rdata, 0);

    // 1: single write from initiator 0
    i0_sel = 1; i0_wr = 1; i0_addr = 32'h10; i0_wdata = 32'hA5A5_A5A5; t_rdy = 1;
    chk("t1_idle_psel", t_sel, 0);
    tick();
    i0_en = 1;
    chk("t1_setup_ctl", {t_sel, t_en, t_wr}, 3'b101);
    chk("t1_setup_addr", t_addr, 32'h10);
    chk("t1_setup_wdata", t_wdata, 32'hA5A5_A5A5);
    chk("t1_setup_rdy0", i0_rdy, 0);
    tick();
    chk("t1_access_ctl", {t_sel, t_en}, 2'b11);
    chk("t1_access_addr", t_addr, 32'h10);
    chk("t1_rdy0", i0_rdy, 1);
    chk("t1_rdy1", i1_rdy, 0);
    i0_sel = 0; i0_en = 0;
    tick();
    chk("t1_back_idle", t_sel, 0);

    // 2: round robin after reset
    reset_dut();
    i0_sel = 1; i1_sel = 1; i0_addr = 32'h100; i1_addr = 32'h200; i0_wr = 0; i1_wr = 0;
    tick();
    chk("t2_a_mux", mux_sel, 0);
    chk("t2_a_addr", t_addr, 32'h100);
    tick();
    chk("t2_a_rdy", {i0_rdy, i1_rdy}, 2'b10);
    i0_sel = 0;
    tick();
    chk("t2_gap_psel", t_sel, 0);
    tick();
    chk("t2_b_mux", mux_sel, 1);
    chk("t2_b_addr", t_addr, 32'h200);
    tick();
    chk("t2_b_rdy", {i0_rdy, i1_rdy}, 2'b01);
    i0_sel = 1;
    tick();
    tick();
    chk("t2_c_mux", mux_sel, 0);
    tick();
    chk("t2_c_rdy", {i0_rdy, i1_rdy}, 2'b10);
    i0_sel = 0; i1_sel = 0;
    tick();

    // 3: initiator 1 read with three wait states
    i1_sel = 1; i1_wr = 0; i1_addr = 32'h20; t_rdy = 0; t_rdata = 32'h1234_5678;
    tick();
    chk("t3_mux", mux_sel, 1);
    tick();
    for (int w = 0; w < 3; w++) begin
      chk("t3_wait_rdy1", i1_rdy, 0);
      chk("t3_wait_rdata1", i1_rdata, 0);
      chk("t3_wait_i0", {i0_rdy, i0_err, i0_rdata}, 0);
      chk("t3_wait_pen", t_en, 1);
      tick();
    end
    t_rdy = 1;
    #1;
    chk("t3_done_rdy1", i1_rdy, 1);
    chk("t3_done_rdata1", i1_rdata, 32'h1234_5678);
    chk("t3_done_i0", {i0_rdy, i0_err, i0_rdata}, 0);
    i1_sel = 0;
    tick();
    chk("t3_after_rdy1", i1_rdy, 0);

    // 4: slave error to initiator 0
    i0_sel = 1; t_err = 1;
    tick();
    chk("t4_setup_err0", i0_err, 0);
    tick();
    chk("t4_done_err0", i0_err, 1);
    chk("t4_done_err1", i1_err, 0);
    i0_sel = 0;
    tick();
    chk("t4_after_err0", i0_err, 0);
    t_err = 0;

    // 5: reset during ACCESS abandons the transfer
    i1_sel = 1; t_rdy = 0;
    tick();
    tick();
    chk("t5_access_mux", mux_sel, 1);
    PRESET = 1; t_rdy = 1;
    #1;
    chk("t5_rst_rdy1", i1_rdy, 0);
    tick();
    PRESET = 0; t_rdy = 0;
    chk("t5_after_ctl", {t_sel, t_en, mux_sel}, 0);
    chk("t5_after_rdy", {i0_rdy, i1_rdy}, 0);
    tick();
    chk("t5_new_setup", {t_sel, t_en, mux_sel}, 3'b101);
    t_rdy = 1;
    tick();
    chk("t5_new_rdy1", i1_rdy, 1);
    i1_sel = 0;
    tick();

    // 6: target stuck at PREADY low
    i0_sel = 1; t_rdy = 0; t_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
`ifdef APB3_ARB_TIMEOUT_EN
    for (int w = 0; w < 4; w++) begin
      chk("t6_wait_rdy0", i0_rdy, 0);
      tick();
    end
    chk("t6_tmo_resp", {i0_rdy, i0_err}, 2'b11);
    chk("t6_tmo_rdata", i0_rdata, 0);
    i0_sel = 0;
    tick();
    chk("t6_tmo_psel", t_sel, 0);
`else
    for (int w = 0; w < 8; w++) begin
      chk("t6_hold_rdy0", i0_rdy, 0);
      chk("t6_hold_psel", t_sel, 1);
      tick();
    end
    t_rdy = 1;
    #1;
    chk("t6_release_rdata", i0_rdata, 32'hDEAD_BEEF);
    i0_sel = 0;
    tick();
    chk("t6_release_psel", t_sel, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
